// File: rtl/mem_if_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_if_pkg
// Purpose  : Types and line geometry shared by the cache controller and the
//            main-memory responder on the main-memory interface.
// Contents : state_t  - responder FSM states
//            op_t     - latched request kind
//            WORDS_PER_LINE, IDX_W and default widths of the interface
// Revision : 1.0 - initial release
// ============================================================================
package mem_if_pkg;

  typedef enum logic [2:0] {
    INIT = 3'd0,
    IDLE = 3'd1,
    WAIT = 3'd2,
    RESP = 3'd3,
    GAP  = 3'd4
  } state_t;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } op_t;

  localparam int DEF_ADDR_W     = 32;
  localparam int DEF_WORD_W     = 32;
  localparam int DEF_LINE_W     = 512;
  localparam int DEF_MEM_WORDS  = 4096;
  localparam int WORDS_PER_LINE = DEF_LINE_W / DEF_WORD_W;
  localparam int IDX_W          = $clog2(DEF_MEM_WORDS);

endpackage
`default_nettype wire

// File: rtl/mem_word_array.sv
`default_nettype none
// ============================================================================
// Module   : mem_word_array
// Purpose  : Backing word store with one synchronous write port and one
//            combinational line-wide read port.
// Ports    : clk       - write clock
//            we        - write enable
//            waddr     - word index to write
//            wdata     - word to write
//            line_base - word index of word 0 of the line (low bits zero)
//            rline     - assembled line, word k at rline[k*WORD_W +: WORD_W]
// Revision : 1.0 - initial release
// ============================================================================
module mem_word_array
  import mem_if_pkg::*;
#(
  parameter int WORD_W    = DEF_WORD_W,
  parameter int LINE_W    = WORDS_PER_LINE * WORD_W,
  parameter int MEM_WORDS = 2 ** IDX_W
) (
  input  logic                         clk,
  input  logic                         we,
  input  logic [$clog2(MEM_WORDS)-1:0] waddr,
  input  logic [WORD_W-1:0]            wdata,
  input  logic [$clog2(MEM_WORDS)-1:0] line_base,
  output logic [LINE_W-1:0]            rline
);

  localparam int c_IDX_W = $clog2(MEM_WORDS);
  localparam int c_WPL   = LINE_W / WORD_W;

  // No reset on the storage: contents are defined by the post-reset fill.
  logic [WORD_W-1:0] r_mem [MEM_WORDS];

  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[waddr] <= wdata;
    end
  end

  genvar k;
  generate
    for (k = 0; k < c_WPL; k++) begin : g_rd_word
      localparam logic [c_IDX_W-1:0] c_K = c_IDX_W'(k);
      // line_base has its offset bits clear, so OR selects word k of the line.
      assign rline[k*WORD_W +: WORD_W] = r_mem[line_base | c_K];
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/main_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : main_mem_responder
// Purpose  : Memory end of the cache controller's main-memory interface.
//            Serves line reads and single-word writes after a fixed latency,
//            with a post-reset fill of the whole store.
// Ports    : clk, rst            - clock, asynchronous active-high reset
//            main_mem_addr       - request byte address (low bits aliased)
//            main_mem_data_out   - write word from the controller
//            main_mem_read_req   - level line-read request
//            main_mem_write_req  - level word-write request
//            main_mem_data_in    - returned line, held until the next read
//            main_mem_ready      - one-cycle completion pulse
//            init_done           - post-reset fill has completed
// Revision : 1.0 - initial release
// ============================================================================
module main_mem_responder
  import mem_if_pkg::*;
#(
  parameter int              ADDR_W    = DEF_ADDR_W,
  parameter int              WORD_W    = DEF_WORD_W,
  parameter int              LINE_W    = WORDS_PER_LINE * WORD_W,
  parameter int              MEM_WORDS = 2 ** IDX_W,
  parameter int              LATENCY   = 4,
  parameter logic [WORD_W-1:0] INIT_WORD = WORD_W'(32'hFFFF_FFFF)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] main_mem_addr,
  input  logic [WORD_W-1:0] main_mem_data_out,
  input  logic              main_mem_read_req,
  input  logic              main_mem_write_req,
  output logic [LINE_W-1:0] main_mem_data_in,
  output logic              main_mem_ready,
  output logic              init_done
);

  localparam int c_IDX_W = $clog2(MEM_WORDS);
  localparam int c_OFF_W = $clog2(LINE_W / WORD_W);
  localparam int c_CNT_W = $clog2(LATENCY) + 1;
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(LATENCY - 1);
  localparam logic [c_IDX_W-1:0] c_PTR_LAST = c_IDX_W'(MEM_WORDS - 1);

  generate
    if ((MEM_WORDS & (MEM_WORDS - 1)) != 0 || MEM_WORDS < (LINE_W / WORD_W)) begin : g_bad_mem_words
      $error("main_mem_responder: MEM_WORDS must be a power of 2 and hold at least one line");
    end
    if (LATENCY < 1) begin : g_bad_latency
      $error("main_mem_responder: LATENCY must be at least 1");
    end
  endgenerate

  state_t              r_state, w_state_nxt;
  logic [c_IDX_W-1:0]  r_fill_ptr;
  logic [c_IDX_W-1:0]  r_idx;
  logic [WORD_W-1:0]   r_wdata;
  op_t                 r_op;
  logic [c_CNT_W-1:0]  r_cnt;
  logic [LINE_W-1:0]   r_data_in;
  logic                r_init_done;

  logic [c_IDX_W-1:0]  w_req_idx;
  logic [c_IDX_W-1:0]  w_line_base;
  logic [LINE_W-1:0]   w_line;
  logic                w_accept_rd, w_accept_wr, w_access, w_fill_last;
  logic                w_mem_we;
  logic [c_IDX_W-1:0]  w_mem_waddr;
  logic [WORD_W-1:0]   w_mem_wdata;
  logic                w_unused_addr_bits;

  // Only the word index bits take part; the rest alias.
  assign w_req_idx          = main_mem_addr[c_IDX_W+1:2];
  assign w_unused_addr_bits = ^{main_mem_addr[ADDR_W-1:c_IDX_W+2], main_mem_addr[1:0]};
  assign w_line_base        = {r_idx[c_IDX_W-1:c_OFF_W], {c_OFF_W{1'b0}}};

  mem_word_array #(
    .WORD_W    (WORD_W),
    .LINE_W    (LINE_W),
    .MEM_WORDS (MEM_WORDS)
  ) u_array (
    .clk       (clk),
    .we        (w_mem_we),
    .waddr     (w_mem_waddr),
    .wdata     (w_mem_wdata),
    .line_base (w_line_base),
    .rline     (w_line)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_accept_rd = 1'b0;
    w_accept_wr = 1'b0;
    w_access    = 1'b0;
    w_fill_last = 1'b0;
    w_mem_we    = 1'b0;
    w_mem_waddr = r_idx;
    w_mem_wdata = r_wdata;
    case (r_state)
      INIT: begin
        w_mem_we    = 1'b1;
        w_mem_waddr = r_fill_ptr;
        w_mem_wdata = INIT_WORD;
        if (r_fill_ptr == c_PTR_LAST) begin
          w_fill_last = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      IDLE: begin
        // Read wins when both requests are raised together.
        if (main_mem_read_req) begin
          w_accept_rd = 1'b1;
          w_state_nxt = WAIT;
        end else if (main_mem_write_req) begin
          w_accept_wr = 1'b1;
          w_state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (r_cnt == c_CNT_LAST) begin
          w_access    = 1'b1;
          w_mem_we    = (r_op == OP_WRITE);
          w_state_nxt = RESP;
        end
      end
      RESP:    w_state_nxt = GAP;
      // GAP keeps a request still held through the ready cycle from being
      // taken a second time.
      GAP:     w_state_nxt = IDLE;
      default: w_state_nxt = INIT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= INIT;
      r_fill_ptr  <= '0;
      r_idx       <= '0;
      r_wdata     <= '0;
      r_op        <= OP_READ;
      r_cnt       <= '0;
      r_data_in   <= '0;
      r_init_done <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == INIT) begin
        r_fill_ptr <= r_fill_ptr + c_IDX_W'(1);
      end
      if (w_fill_last) begin
        r_init_done <= 1'b1;
      end
      if (w_accept_rd || w_accept_wr) begin
        r_idx <= w_req_idx;
        r_op  <= w_accept_rd ? OP_READ : OP_WRITE;
        r_cnt <= '0;
      end else if (r_state == WAIT) begin
        r_cnt <= r_cnt + c_CNT_W'(1);
      end
      if (w_accept_wr) begin
        r_wdata <= main_mem_data_out;
      end
      if (w_access && r_op == OP_READ) begin
        r_data_in <= w_line;
      end
    end
  end

  assign main_mem_ready   = (r_state == RESP);
  assign main_mem_data_in = r_data_in;
  assign init_done        = r_init_done;

endmodule
`default_nettype wire

// File: tb/tb_main_mem_responder.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_main_mem_responder
// Purpose  : Self-checking bench for main_mem_responder: directed steps and
//            randomized traffic against a word-array reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_main_mem_responder;

  localparam int ADDR_W    = 32;
  localparam int WORD_W    = 32;
  localparam int LINE_W    = 512;
  localparam int MEM_WORDS = 4096;
  localparam int LATENCY   = 4;
  localparam int WPL       = LINE_W / WORD_W;
  localparam int TIMEOUT   = 64;
  localparam logic [WORD_W-1:0] FILL = 32'hFFFF_FFFF;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [ADDR_W-1:0] addr = '0;
  logic [WORD_W-1:0] wdata = '0;
  logic              read_req = 1'b0;
  logic              write_req = 1'b0;
  logic [LINE_W-1:0] data_in;
  logic              ready;
  logic              init_done;

  main_mem_responder #(
    .ADDR_W    (ADDR_W),
    .WORD_W    (WORD_W),
    .LINE_W    (LINE_W),
    .MEM_WORDS (MEM_WORDS),
    .LATENCY   (LATENCY),
    .INIT_WORD (FILL)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .main_mem_addr      (addr),
    .main_mem_data_out  (wdata),
    .main_mem_read_req  (read_req),
    .main_mem_write_req (write_req),
    .main_mem_data_in   (data_in),
    .main_mem_ready     (ready),
    .init_done          (init_done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [WORD_W-1:0] mdl_mem [MEM_WORDS];

  task automatic check(input string tag, input logic [LINE_W-1:0] obs, input logic [LINE_W-1:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int idx_of(input logic [ADDR_W-1:0] a);
    return int'(a[13:2]);
  endfunction

  function automatic logic [LINE_W-1:0] line_of(input logic [ADDR_W-1:0] a);
    logic [LINE_W-1:0] l;
    int base;
    base = (idx_of(a) / WPL) * WPL;
    for (int k = 0; k < WPL; k++) l[k*WORD_W +: WORD_W] = mdl_mem[base + k];
    return l;
  endfunction

  task automatic mdl_fill();
    for (int i = 0; i < MEM_WORDS; i++) mdl_mem[i] = FILL;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Counts edges until ready is seen; an expired budget is a failed check.
  task automatic wait_ready(input string tag, output int edges);
    edges = 0;
    do begin
      tick();
      edges++;
    end while (!ready && edges < TIMEOUT);
    if (!ready) check({tag, "_timeout"}, LINE_W'(1'b0), LINE_W'(1'b1));
  endtask

  // Counts edges until init_done rises after reset release.
  task automatic wait_fill(input string tag);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (!init_done && n < MEM_WORDS + 100);
    check(tag, LINE_W'(n), LINE_W'(MEM_WORDS));
  endtask

  // One complete transaction from an idle responder.
  task automatic do_op(input bit is_rd, input logic [ADDR_W-1:0] a,
                       input logic [WORD_W-1:0] d, input string tag);
    logic [LINE_W-1:0] prior;
    bit                stable;
    int                edges;
    tick();
    tick();
    prior  = data_in;
    stable = 1'b1;
    addr   = a;
    wdata  = d;
    if (is_rd) read_req = 1'b1;
    else       write_req = 1'b1;
    edges = 0;
    do begin
      tick();
      edges++;
      if (data_in !== prior && !is_rd) stable = 1'b0;
    end while (!ready && edges < TIMEOUT);
    read_req  = 1'b0;
    write_req = 1'b0;
    check({tag, "_latency"}, LINE_W'(edges), LINE_W'(LATENCY + 1));
    if (is_rd) begin
      check({tag, "_line"}, data_in, line_of(a));
    end else begin
      mdl_mem[idx_of(a)] = d;
      check({tag, "_data_held"}, LINE_W'(stable), LINE_W'(1'b1));
    end
    tick();
    check({tag, "_pulse_width"}, LINE_W'(ready), LINE_W'(1'b0));
  endtask

  logic [7:0] lines [4] = '{8'h40, 8'h41, 8'h80, 8'hFF};

  initial begin
    int edges;
    int pulses;
    logic [LINE_W-1:0] saved;
    logic [ADDR_W-1:0] ra;

    // Reset values.
    #2 rst = 1'b1;
    #1;
    check("rst_data_in", data_in, '0);
    check("rst_ready", LINE_W'(ready), LINE_W'(1'b0));
    check("rst_init_done", LINE_W'(init_done), LINE_W'(1'b0));
    mdl_fill();
    repeat (2) tick();

    // Read held through the fill, accepted once IDLE is reached.
    rst      = 1'b0;
    addr     = 32'h0000_1000;
    read_req = 1'b1;
    wait_fill("fill_cycles");
    wait_ready("init_read", edges);
    read_req = 1'b0;
    check("init_read_latency", LINE_W'(edges), LINE_W'(LATENCY + 1));
    check("init_read_line", data_in, {LINE_W{1'b1}});

    // Word write then line read, plus aliased read.
    do_op(1'b0, 32'h0000_1044, 32'hDEAD_BEEF, "wr_1044");
    do_op(1'b1, 32'h0000_1040, '0, "rd_1040");
    check("rd_1040_word1", LINE_W'(data_in[63:32]), LINE_W'(32'hDEAD_BEEF));
    do_op(1'b1, 32'h0000_5040, '0, "rd_5040_alias");
    check("alias_word1", LINE_W'(data_in[63:32]), LINE_W'(32'hDEAD_BEEF));

    // Simultaneous read and write: read first, write L+3 edges later.
    tick();
    tick();
    addr      = 32'h0000_1000;
    wdata     = 32'h1234_5678;
    read_req  = 1'b1;
    write_req = 1'b1;
    wait_ready("both_read", edges);
    check("both_read_latency", LINE_W'(edges), LINE_W'(LATENCY + 1));
    check("both_read_line", data_in, line_of(32'h0000_1000));
    saved    = data_in;
    read_req = 1'b0;
    addr     = 32'h0000_1004;
    wait_ready("both_write", edges);
    write_req = 1'b0;
    check("both_write_spacing", LINE_W'(edges), LINE_W'(LATENCY + 3));
    check("both_write_data_held", data_in, saved);
    mdl_mem[idx_of(32'h0000_1004)] = 32'h1234_5678;
    do_op(1'b1, 32'h0000_1000, '0, "rd_1000");
    check("rd_1000_word1", LINE_W'(data_in[63:32]), LINE_W'(32'h1234_5678));

    // Read held two edges past ready: exactly one completion.
    tick();
    tick();
    addr     = 32'h0000_1040;
    read_req = 1'b1;
    wait_ready("hold_read", edges);
    check("hold_read_latency", LINE_W'(edges), LINE_W'(LATENCY + 1));
    tick();
    tick();
    read_req = 1'b0;
    pulses   = 0;
    for (int i = 0; i < LATENCY + 5; i++) begin
      tick();
      if (ready) pulses++;
    end
    check("hold_no_second_pulse", LINE_W'(pulses), '0);

    // Reset during the wait of a write: write lost, fill restarts.
    do_op(1'b0, 32'h0000_2004, 32'h1111_2222, "wr_2004");
    tick();
    tick();
    addr      = 32'h0000_2000;
    wdata     = 32'hA5A5_A5A5;
    write_req = 1'b1;
    tick();
    tick();
    rst = 1'b1;
    #1;
    check("midrst_ready", LINE_W'(ready), LINE_W'(1'b0));
    check("midrst_init_done", LINE_W'(init_done), LINE_W'(1'b0));
    check("midrst_data_in", data_in, '0);
    write_req = 1'b0;
    tick();
    tick();
    check("midrst_ready_held", LINE_W'(ready), LINE_W'(1'b0));
    rst = 1'b0;
    mdl_fill();
    wait_fill("refill_cycles");
    do_op(1'b1, 32'h0000_2000, '0, "rd_2000");
    check("rd_2000_word0", LINE_W'(data_in[31:0]), LINE_W'(FILL));

    // Randomized traffic over a few lines, with random aliased upper bits.
    for (int n = 0; n < 40; n++) begin
      ra       = $urandom;
      ra[13:6] = lines[$urandom_range(0, 3)];
      ra[5:2]  = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 1) == 1) do_op(1'b1, ra, '0, "rand_rd");
      else                           do_op(1'b0, ra, $urandom, "rand_wr");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
